// File: rtl/dyn_phase_seq_pkg.sv
// Shared types and constants for the multi-step PLL dynamic phase-shift sequencer.
package dyn_phase_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STEP    = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4,
        S_NEXT    = 3'd5
    } state_t;

    // PHASECOUNTERSELECT codes: 0 = all counters, 1 = M counter, 2+k = output counter Ck
    localparam logic [3:0] CSEL_ALL = 4'h0;
    localparam logic [3:0] CSEL_M   = 4'h1;
    localparam logic [3:0] CSEL_C0  = 4'h2;

    // A select code is usable when it names "all", M, or one of the tracked Ck counters
    function automatic logic sel_legal(input logic [3:0] sel, input int num_cnt);
        return int'(sel) <= num_cnt + 1;
    endfunction

endpackage

// File: rtl/dyn_phase_seq_if.sv
// Command bus between the dyn_phase register block (master) and the sequencer (slave).
interface dyn_phase_seq_if #(
    parameter int STEP_W = 10
);
    logic              valid;
    logic              ready;
    logic [3:0]        sel;
    logic              up;
    logic [STEP_W-1:0] steps;
    logic              abort;
    logic              offset_clr;

    modport master (output valid, sel, up, steps, abort, offset_clr, input ready);
    modport slave  (input valid, sel, up, steps, abort, offset_clr, output ready);
endinterface

// File: rtl/dyn_phase_seq_sync2.sv
// Two-flop synchroniser bringing the PLL's asynchronous PHASEDONE into the scan clock domain.
module dyn_phase_seq_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // Plain two-stage shift register; reset clears both stages
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/dyn_phase_seq.sv
// Multi-step PLL dynamic phase-shift sequencer: runs N PHASESTEP/PHASEDONE handshakes per
// command, tracks a signed net offset per output counter, and handles timeout/abort/bad select.
module dyn_phase_seq
    import dyn_phase_seq_pkg::*;
#(
    parameter int NUM_CNT = 5,
    parameter int STEP_W  = 10,
    parameter int OFS_W   = 12,
    parameter int PS_HOLD = 2,
    parameter int TMO_CYC = 1023
) (
    input  logic                     clk50m,
    input  logic                     reset,
    dyn_phase_seq_if.slave           cmd,
    output logic                     busy,
    output logic                     done,
    output logic                     err_tmo,
    output logic                     err_sel,
    output logic [NUM_CNT*OFS_W-1:0] phase_offset,
    input  logic                     phasedone,
    output logic [3:0]               phasecounterselect,
    output logic                     phaseupdown,
    output logic                     phasestep
);
    localparam int HOLD_W = $clog2(PS_HOLD) + 1;
    localparam int TMO_W  = $clog2(TMO_CYC) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PS_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYC - 1);

    state_t            state, state_next;
    logic              done_sync;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [3:0]        sel_q;
    logic              up_q;
    logic [STEP_W-1:0] remaining;
    logic              abort_q;
    logic [OFS_W-1:0]  ofs [NUM_CNT];
    logic              accept, sel_bad, step_ok, finish, timeout;

    dyn_phase_seq_sync2 u_sync (
        .clk   (clk50m),
        .reset (reset),
        .d     (phasedone),
        .q     (done_sync)
    );

    assign cmd.ready          = (state == S_IDLE);
    assign busy               = (state != S_IDLE);
    assign phasestep          = (state == S_STEP);
    assign phasecounterselect = sel_q;
    assign phaseupdown        = up_q;

    // State register
    always_ff @(posedge clk50m) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode plus one-cycle event strobes for the datapath
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sel_bad    = 1'b0;
        step_ok    = 1'b0;
        finish     = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd.valid) begin
                    if (!sel_legal(cmd.sel, NUM_CNT)) begin
                        sel_bad = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (cmd.steps != '0) state_next = S_SETUP;
                    end
                end
            end
            S_SETUP: state_next = S_STEP;
            S_STEP: begin
                if (hold_cnt == HOLD_LAST) state_next = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!done_sync) begin
                    state_next = S_WAIT_HI;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_WAIT_HI: begin
                if (done_sync) begin
                    state_next = S_NEXT;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_NEXT: begin
                step_ok = 1'b1;
                if (remaining == STEP_W'(1) || abort_q || cmd.abort) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_SETUP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // PHASESTEP hold timer and per-wait-state timeout counter, both restart on every state entry
    always_ff @(posedge clk50m) begin
        if (reset) begin
            hold_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            hold_cnt <= (state == S_STEP) ? hold_cnt + 1'b1 : '0;
            tmo_cnt  <= ((state == S_WAIT_LO || state == S_WAIT_HI) && state_next == state)
                        ? tmo_cnt + 1'b1 : '0;
        end
    end

    // Command latch, step countdown, abort latch and status flags
    always_ff @(posedge clk50m) begin
        if (reset) begin
            sel_q     <= CSEL_ALL;
            up_q      <= 1'b0;
            remaining <= '0;
            abort_q   <= 1'b0;
            err_tmo   <= 1'b0;
            err_sel   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= (accept && cmd.steps == '0) || finish || timeout;
            err_sel <= sel_bad;
            if (accept) begin
                sel_q     <= cmd.sel;
                up_q      <= cmd.up;
                remaining <= cmd.steps;
                abort_q   <= 1'b0;
                err_tmo   <= 1'b0;
            end else begin
                if (timeout) err_tmo <= 1'b1;
                if (busy && cmd.abort) abort_q <= 1'b1;
                if (step_ok) remaining <= remaining - 1'b1;
            end
        end
    end

    // Signed per-counter offsets: +/-1 for every completed step on the selected counter(s)
    always_ff @(posedge clk50m) begin
        for (int k = 0; k < NUM_CNT; k++) begin
            if (reset || (cmd.offset_clr && state == S_IDLE)) begin
                ofs[k] <= '0;
            end else if (step_ok && (sel_q == CSEL_ALL || sel_q == CSEL_C0 + 4'(k))) begin
                ofs[k] <= up_q ? ofs[k] + OFS_W'(1) : ofs[k] - OFS_W'(1);
            end
        end
    end

    // Flatten the offset array onto the output bus, Ck in slice k
    always_comb begin
        phase_offset = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            phase_offset[k*OFS_W +: OFS_W] = ofs[k];
        end
    end

endmodule

// File: tb/tb_dyn_phase_seq.sv
// Directed testbench for dyn_phase_seq with a simple ALTPLL PHASEDONE model and pulse monitor.
module tb_dyn_phase_seq;
    localparam int NUM_CNT = 5;
    localparam int STEP_W  = 10;
    localparam int OFS_W   = 12;

    logic                     clk50m = 1'b0;
    logic                     reset;
    logic                     busy, done, err_tmo, err_sel;
    logic [NUM_CNT*OFS_W-1:0] phase_offset;
    logic                     phasedone;
    logic [3:0]               phasecounterselect;
    logic                     phaseupdown, phasestep;

    dyn_phase_seq_if #(.STEP_W(STEP_W)) cmd_bus ();

    dyn_phase_seq #(
        .NUM_CNT (NUM_CNT),
        .STEP_W  (STEP_W),
        .OFS_W   (OFS_W),
        .PS_HOLD (2),
        .TMO_CYC (1023)
    ) dut (
        .clk50m             (clk50m),
        .reset              (reset),
        .cmd                (cmd_bus),
        .busy               (busy),
        .done               (done),
        .err_tmo            (err_tmo),
        .err_sel            (err_sel),
        .phase_offset       (phase_offset),
        .phasedone          (phasedone),
        .phasecounterselect (phasecounterselect),
        .phaseupdown        (phaseupdown),
        .phasestep          (phasestep)
    );

    int         checks = 0;
    int         errors = 0;
    int         step_starts = 0;
    int         width_bad = 0;
    int         updown_bad = 0;
    int         done_cnt = 0;
    int         ps_width = 0;
    int         pll_cnt = 0;
    int         pll_dly = 5;
    bit         pll_on = 1'b1;
    bit         exp_up = 1'b1;
    bit         ps_prev = 1'b0;
    int         cyc;
    int         busy_gap;
    logic [11:0] exp_ofs [NUM_CNT];

    always #5 clk50m = ~clk50m;

    // PLL model and pulse monitor, evaluated on the falling edge away from DUT sampling
    always @(negedge clk50m) begin
        if (phasestep && !ps_prev) begin
            step_starts++;
            if (pll_on) begin
                phasedone = 1'b0;
                pll_cnt   = pll_dly;
            end
        end else if (pll_cnt > 0) begin
            pll_cnt--;
            if (pll_cnt == 0) phasedone = 1'b1;
        end
        if (phasestep) begin
            ps_width++;
            if (phaseupdown !== exp_up) updown_bad++;
        end else if (ps_width != 0) begin
            if (ps_width != 2) width_bad++;
            ps_width = 0;
        end
        if (done === 1'b1) done_cnt++;
        ps_prev = phasestep;
    end

    function automatic logic [NUM_CNT*OFS_W-1:0] expVec();
        logic [NUM_CNT*OFS_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CNT; k++) v[k*OFS_W +: OFS_W] = exp_ofs[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk50m);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input bit up, input int steps);
        cmd_bus.valid = 1'b1;
        cmd_bus.sel   = sel;
        cmd_bus.up    = up;
        cmd_bus.steps = STEP_W'(steps);
        tick();
        cmd_bus.valid = 1'b0;
    endtask

    task automatic waitDone(input int max_cyc);
        cyc      = 0;
        busy_gap = 0;
        while (done !== 1'b1 && cyc < max_cyc) begin
            if (busy !== 1'b1) busy_gap++;
            tick();
            cyc++;
        end
    endtask

    initial begin
        int s0, d0, t0;
        reset              = 1'b1;
        phasedone          = 1'b1;
        cmd_bus.valid      = 1'b0;
        cmd_bus.sel        = 4'h0;
        cmd_bus.up         = 1'b0;
        cmd_bus.steps      = '0;
        cmd_bus.abort      = 1'b0;
        cmd_bus.offset_clr = 1'b0;
        for (int k = 0; k < NUM_CNT; k++) exp_ofs[k] = 12'h000;
        repeat (3) tick();

        // Reset values
        checkOutput("rst_ready", cmd_bus.ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_tmo", err_tmo, 0);
        checkOutput("rst_err_sel", err_sel, 0);
        checkOutput("rst_offset", phase_offset, 0);
        checkOutput("rst_pcs", phasecounterselect, 0);
        checkOutput("rst_updown", phaseupdown, 0);
        checkOutput("rst_step", phasestep, 0);
        reset = 1'b0;
        repeat (2) tick();

        // C0 up by 3
        s0 = step_starts; d0 = done_cnt; exp_up = 1'b1;
        applyStimulus(4'h2, 1'b1, 3);
        checkOutput("c0up_busy", busy, 1);
        checkOutput("c0up_pcs", phasecounterselect, 4'h2);
        waitDone(300);
        checkOutput("c0up_done_seen", done, 1);
        repeat (3) tick();
        exp_ofs[0] = 12'h003;
        checkOutput("c0up_pulses", step_starts - s0, 3);
        checkOutput("c0up_width_bad", width_bad, 0);
        checkOutput("c0up_done_cnt", done_cnt - d0, 1);
        checkOutput("c0up_offset", phase_offset, expVec());
        checkOutput("c0up_ready", cmd_bus.ready, 1);

        // All counters down by 2
        s0 = step_starts; exp_up = 1'b0;
        applyStimulus(4'h0, 1'b0, 2);
        waitDone(300);
        checkOutput("all_dn_done_seen", done, 1);
        checkOutput("all_dn_busy_gap", busy_gap, 0);
        repeat (3) tick();
        exp_ofs[0] = 12'h001;
        for (int k = 1; k < NUM_CNT; k++) exp_ofs[k] = 12'hFFE;
        checkOutput("all_dn_pulses", step_starts - s0, 2);
        checkOutput("all_dn_updown_bad", updown_bad, 0);
        checkOutput("all_dn_offset", phase_offset, expVec());

        // PHASEDONE never falls: timeout in WAIT_LO
        pll_on = 1'b0; phasedone = 1'b1; exp_up = 1'b1;
        s0 = step_starts; d0 = done_cnt;
        applyStimulus(4'h3, 1'b1, 1);
        waitDone(1200);
        checkOutput("tmo_done_seen", done, 1);
        checkOutput("tmo_latency_window", (cyc >= 1020 && cyc <= 1032), 1);
        repeat (3) tick();
        checkOutput("tmo_err", err_tmo, 1);
        checkOutput("tmo_done_cnt", done_cnt - d0, 1);
        checkOutput("tmo_pulses", step_starts - s0, 1);
        checkOutput("tmo_offset", phase_offset, expVec());
        pll_on = 1'b1;

        // Offset clear while idle
        cmd_bus.offset_clr = 1'b1;
        tick();
        cmd_bus.offset_clr = 1'b0;
        for (int k = 0; k < NUM_CNT; k++) exp_ofs[k] = 12'h000;
        checkOutput("clr_offset", phase_offset, expVec());

        // Abort during second of five steps on C2
        s0 = step_starts; d0 = done_cnt;
        applyStimulus(4'h4, 1'b1, 5);
        checkOutput("abort_err_tmo_cleared", err_tmo, 0);
        t0 = 0;
        while (step_starts - s0 < 2 && t0 < 200) begin
            tick();
            t0++;
        end
        checkOutput("abort_second_step_seen", step_starts - s0 >= 2, 1);
        cmd_bus.abort = 1'b1;
        tick();
        cmd_bus.abort = 1'b0;
        waitDone(300);
        checkOutput("abort_done_seen", done, 1);
        repeat (3) tick();
        exp_ofs[2] = 12'h002;
        checkOutput("abort_pulses", step_starts - s0, 2);
        checkOutput("abort_offset", phase_offset, expVec());
        checkOutput("abort_done_cnt", done_cnt - d0, 1);
        checkOutput("abort_ready", cmd_bus.ready, 1);

        // Illegal select 0x9
        s0 = step_starts; d0 = done_cnt;
        applyStimulus(4'h9, 1'b1, 4);
        checkOutput("badsel_err_sel", err_sel, 1);
        checkOutput("badsel_ready", cmd_bus.ready, 1);
        checkOutput("badsel_busy", busy, 0);
        tick();
        checkOutput("badsel_err_sel_pulse", err_sel, 0);
        repeat (3) tick();
        checkOutput("badsel_pulses", step_starts - s0, 0);
        checkOutput("badsel_done_cnt", done_cnt - d0, 0);

        // Zero-step command
        applyStimulus(4'h2, 1'b1, 0);
        checkOutput("n0_done", done, 1);
        checkOutput("n0_busy", busy, 0);
        tick();
        checkOutput("n0_done_pulse", done, 0);
        checkOutput("n0_offset", phase_offset, expVec());

        // Walk C4 to 0x7FF then wrap to 0x800
        pll_dly = 2;
        applyStimulus(4'h6, 1'b1, 1023);
        waitDone(15000);
        checkOutput("wrap_a_done_seen", done, 1);
        tick();
        applyStimulus(4'h6, 1'b1, 1023);
        waitDone(15000);
        checkOutput("wrap_b_done_seen", done, 1);
        tick();
        applyStimulus(4'h6, 1'b1, 1);
        waitDone(300);
        checkOutput("wrap_c_done_seen", done, 1);
        tick();
        exp_ofs[4] = 12'h7FF;
        checkOutput("wrap_7ff", phase_offset, expVec());
        applyStimulus(4'h6, 1'b1, 1);
        waitDone(300);
        tick();
        exp_ofs[4] = 12'h800;
        checkOutput("wrap_800", phase_offset, expVec());

        // Reset while in WAIT_HI
        pll_dly = 5; d0 = done_cnt;
        applyStimulus(4'h2, 1'b1, 3);
        t0 = 0;
        while (phasedone !== 1'b0 && t0 < 100) begin tick(); t0++; end
        while (phasedone !== 1'b1 && t0 < 200) begin tick(); t0++; end
        checkOutput("midrst_reached_wait_hi", (t0 < 200) && busy, 1);
        reset = 1'b1;
        tick();
        for (int k = 0; k < NUM_CNT; k++) exp_ofs[k] = 12'h000;
        checkOutput("midrst_ready", cmd_bus.ready, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_offset", phase_offset, expVec());
        checkOutput("midrst_pcs", phasecounterselect, 0);
        checkOutput("midrst_step", phasestep, 0);
        reset = 1'b0;
        repeat (5) tick();
        checkOutput("midrst_no_done", done_cnt - d0, 0);
        checkOutput("midrst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
